regfile_write_arbiter: RTL and testbench

Shares the single register-file write port between the pipeline writeback stage and a multi-cycle execution unit (mul/div, late loads). Pipeline writeback always wins and passes through in the same cycle. Multi-cycle results are buffered in a small FIFO and drained into idle write slots. The block also reports pending buffered destinations to decode for hazard stalls, and can force a pipeline bubble when a buffered result starves.

---
 rtl/regfile_write_arbiter.sv | 148 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between pipeline writeback
// (always wins, combinational pass-through) and a small FIFO of results
// from the multi-cycle unit. Buffered results drain into idle write slots.
// Decode is told which destinations are still buffered. Writebacks to the
// same register kill older buffered entries (WAW).
// Optional starvation guard, enabled by defining
// REGFILE_WRITE_ARB_STARVE_GUARD_EN: a head that waits MAX_WAIT cycles
// raises stall_req so the pipeline inserts a bubble.

module regfile_write_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [4:0]                   wb_reg,
  input  logic [31:0]                  wb_data,
  input  logic                         mu_valid,
  output logic                         mu_ready,
  input  logic [4:0]                   mu_reg,
  input  logic [31:0]                  mu_data,
  output logic [4:0]                   rf_r3,
  output logic [31:0]                  rf_data,
  input  logic [4:0]                   chk1_reg,
  input  logic [4:0]                   chk2_reg,
  output logic                         chk1_hit,
  output logic                         chk2_hit,
  output logic                         stall_req,
  output logic [$clog2(DEPTH+1)-1:0]   pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Slots that are not live always hold reg = 0, so the hazard check can
  // simply scan every slot without looking at the pointers.
  logic [4:0]    ent_reg  [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          empty;
  logic [4:0]    head_reg;
  logic [31:0]   head_data;
  logic          pop;
  logic          push;
  logic          enq;

  assign empty     = (count == '0);
  assign head_reg  = ent_reg[rd_ptr];
  assign head_data = ent_data[rd_ptr];
  assign mu_ready  = (count != FULL);
  assign push      = mu_valid && mu_ready;
  assign enq       = push && (mu_reg != 5'd0);
  assign pop       = !empty && ((head_reg == 5'd0) || (wb_reg == 5'd0));
  assign pending   = count;

  // Write-port select: writeback first, then a live FIFO head, else idle.
  always_comb begin
    rf_r3   = 5'd0;
    rf_data = 32'd0;
    if (wb_reg != 5'd0) begin
      rf_r3   = wb_reg;
      rf_data = wb_data;
    end else if (!empty && (head_reg != 5'd0)) begin
      rf_r3   = head_reg;
      rf_data = head_data;
    end
  end

  // Hazard check against every buffered destination.
  always_comb begin
    chk1_hit = 1'b0;
    chk2_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((chk1_reg != 5'd0) && (ent_reg[i] == chk1_reg)) chk1_hit = 1'b1;
      if ((chk2_reg != 5'd0) && (ent_reg[i] == chk2_reg)) chk2_hit = 1'b1;
    end
  end

  // Entry destinations: WAW kill, then clear the popped slot, then the new
  // push last so a same-cycle push to the writeback register survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent_reg[i] <= 5'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if ((wb_reg != 5'd0) && (ent_reg[i] == wb_reg)) ent_reg[i] <= 5'd0;
      end
      if (pop) ent_reg[rd_ptr] <= 5'd0;
      if (enq) ent_reg[wr_ptr] <= mu_reg;
    end
  end

  // Entry data needs no reset; it is only observed behind a live reg.
  always_ff @(posedge clk) begin
    if (enq) ent_data[wr_ptr] <= mu_data;
  end

  // Pointers and occupancy; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef REGFILE_WRITE_ARB_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

  logic [WW-1:0] wait_cnt;
  logic          stall_q;

  // Count blocked cycles of a non-empty head (saturating); request a bubble
  // one edge after the limit is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      stall_q <= (wait_cnt >= WAIT_LIMIT);
      if (empty || pop)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_LIMIT)
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

  assign stall_req = stall_q;
`else
  // Guard disabled: no bubble is ever requested (expression is constant 0).
  assign stall_req = (MAX_WAIT < 0);
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed and randomized stimulus; a queue-based reference model predicts
// every cycle's outputs, which a separate monitor compares at the negedge.
// Starvation expectations follow REGFILE_WRITE_ARB_STARVE_GUARD_EN.

module tb_regfile_write_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
  localparam int CW       = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    wb_reg = '0;
  logic [31:0]   wb_data = '0;
  logic          mu_valid = 1'b0;
  logic          mu_ready;
  logic [4:0]    mu_reg = '0;
  logic [31:0]   mu_data = '0;
  logic [4:0]    rf_r3;
  logic [31:0]   rf_data;
  logic [4:0]    chk1_reg = '0;
  logic [4:0]    chk2_reg = '0;
  logic          chk1_hit;
  logic          chk2_hit;
  logic          stall_req;
  logic [CW-1:0] pending;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .wb_reg(wb_reg), .wb_data(wb_data),
    .mu_valid(mu_valid), .mu_ready(mu_ready), .mu_reg(mu_reg), .mu_data(mu_data),
    .rf_r3(rf_r3), .rf_data(rf_data),
    .chk1_reg(chk1_reg), .chk2_reg(chk2_reg),
    .chk1_hit(chk1_hit), .chk2_hit(chk2_hit),
    .stall_req(stall_req), .pending(pending)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic [4:0]    rf_r3;
    logic [31:0]   rf_data;
    logic          data_valid;
    logic [CW-1:0] pending;
    logic          mu_ready;
    logic          hit1;
    logic          hit2;
    logic          stall;
  } exp_t;

  ent_t  mq[$];
  exp_t  exp_q[$];
  logic  mstall = 1'b0;
`ifdef REGFILE_WRITE_ARB_STARVE_GUARD_EN
  int    mwait = 0;
`endif

  logic [4:0]  cur_wb = '0, cur_mreg = '0, cur_c1 = '0, cur_c2 = '0;
  logic [31:0] cur_wdata = '0, cur_mdata = '0;
  logic        cur_mvalid = 1'b0;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               name, cycle, actual, expected);
    end
  endtask

  // Outputs the model predicts for the inputs currently applied.
  function automatic exp_t modelOutputs();
    exp_t e;
    e.rf_r3      = 5'd0;
    e.rf_data    = 32'd0;
    e.data_valid = 1'b1;
    if (cur_wb != 5'd0) begin
      e.rf_r3   = cur_wb;
      e.rf_data = cur_wdata;
    end else if (mq.size() > 0) begin
      if (mq[0].r != 5'd0) begin
        e.rf_r3   = mq[0].r;
        e.rf_data = mq[0].d;
      end else begin
        e.data_valid = 1'b0;
      end
    end
    e.pending  = CW'(mq.size());
    e.mu_ready = (mq.size() < DEPTH);
    e.hit1 = 1'b0;
    e.hit2 = 1'b0;
    foreach (mq[i]) begin
      if (cur_c1 != 5'd0 && mq[i].r == cur_c1) e.hit1 = 1'b1;
      if (cur_c2 != 5'd0 && mq[i].r == cur_c2) e.hit2 = 1'b1;
    end
    e.stall = mstall;
    return e;
  endfunction

  // Advance the model across one clock edge with the current inputs.
  function automatic void modelStep();
    bit   popped;
    bit   accepted;
    ent_t ne;
    popped   = (mq.size() > 0) && ((mq[0].r == 5'd0) || (cur_wb == 5'd0));
    accepted = cur_mvalid && (mq.size() < DEPTH);
`ifdef REGFILE_WRITE_ARB_STARVE_GUARD_EN
    mstall = (mwait >= MAX_WAIT);
    if (mq.size() == 0 || popped) mwait = 0;
    else mwait++;
`else
    mstall = 1'b0;
`endif
    if (popped) void'(mq.pop_front());
    if (cur_wb != 5'd0)
      foreach (mq[i]) if (mq[i].r == cur_wb) mq[i].r = 5'd0;
    if (accepted && cur_mreg != 5'd0) begin
      ne.r = cur_mreg;
      ne.d = cur_mdata;
      mq.push_back(ne);
    end
  endfunction

  task automatic driveInputs(input logic [4:0] w_reg, input logic [31:0] w_data,
                             input logic m_valid, input logic [4:0] m_reg,
                             input logic [31:0] m_data,
                             input logic [4:0] c1, input logic [4:0] c2);
    cur_wb = w_reg;  cur_wdata = w_data;
    cur_mvalid = m_valid; cur_mreg = m_reg; cur_mdata = m_data;
    cur_c1 = c1; cur_c2 = c2;
    wb_reg = w_reg;  wb_data = w_data;
    mu_valid = m_valid; mu_reg = m_reg; mu_data = m_data;
    chk1_reg = c1; chk2_reg = c2;
  endtask

  // One cycle: the edge commits the previous inputs, then new inputs are
  // applied and their expected outputs queued for the monitor.
  task automatic applyStimulus(input logic [4:0] w_reg, input logic [31:0] w_data,
                               input logic m_valid, input logic [4:0] m_reg,
                               input logic [31:0] m_data,
                               input logic [4:0] c1, input logic [4:0] c2);
    @(posedge clk);
    modelStep();
    #1;
    driveInputs(w_reg, w_data, m_valid, m_reg, m_data, c1, c2);
    exp_q.push_back(modelOutputs());
  endtask

  // Monitor: compare whatever expectation is outstanding at each negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("rf_r3", 32'(rf_r3), 32'(e.rf_r3));
        if (e.data_valid) checkOutput("rf_data", rf_data, e.rf_data);
        checkOutput("pending", 32'(pending), 32'(e.pending));
        checkOutput("mu_ready", 32'(mu_ready), 32'(e.mu_ready));
        checkOutput("chk1_hit", 32'(chk1_hit), 32'(e.hit1));
        checkOutput("chk2_hit", 32'(chk2_hit), 32'(e.hit2));
        checkOutput("stall_req", 32'(stall_req), 32'(e.stall));
      end
    end
  end

  // Asynchronous reset in mid-cycle with entries buffered.
  task automatic resetMidCycle(input logic [4:0] probe1, input logic [4:0] probe2);
    #1;
    checkOutput("pending_before_reset", 32'(pending), 32'd3);
    reset = 1'b1;
    driveInputs(5'd9, 32'h1234_5678, 1'b0, 5'd0, 32'd0, probe1, probe2);
    #1;
    checkOutput("reset_pending", 32'(pending), 32'd0);
    checkOutput("reset_stall", 32'(stall_req), 32'd0);
    checkOutput("reset_chk1_hit", 32'(chk1_hit), 32'd0);
    checkOutput("reset_chk2_hit", 32'(chk2_hit), 32'd0);
    checkOutput("reset_rf_r3", 32'(rf_r3), 32'd9);
    checkOutput("reset_mu_ready", 32'(mu_ready), 32'd1);
    exp_q.delete();
    mq.delete();
    mstall = 1'b0;
`ifdef REGFILE_WRITE_ARB_STARVE_GUARD_EN
    mwait = 0;
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    driveInputs(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  initial begin
    $display("[TB] start");
    // Reset state while reset is held.
    driveInputs(5'd3, 32'hA5A5_0003, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("init_pending", 32'(pending), 32'd0);
    checkOutput("init_mu_ready", 32'(mu_ready), 32'd1);
    checkOutput("init_stall", 32'(stall_req), 32'd0);
    checkOutput("init_chk1_hit", 32'(chk1_hit), 32'd0);
    checkOutput("init_rf_r3", 32'(rf_r3), 32'd3);
    @(posedge clk);
    #1;
    reset = 1'b0;
    driveInputs(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    // Writeback pass-through with empty FIFO.
    applyStimulus(5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #2;
    checkOutput("wb_pass_reg", 32'(rf_r3), 32'd5);
    checkOutput("wb_pass_data", rf_data, 32'hDEAD_BEEF);

    // Fill the FIFO while writeback is busy, then drain in order.
    for (int i = 0; i < 4; i++)
      applyStimulus(5'd1, 32'h100 + 32'(i), 1'b1, 5'(8 + i), 32'hC0DE_0000 + 32'(i), 5'd9, 5'd11);
    applyStimulus(5'd1, 32'h104, 1'b1, 5'd13, 32'hBAD0_0013, 5'd13, 5'd8);
    #2;
    checkOutput("full_pending", 32'(pending), 32'd4);
    checkOutput("full_mu_ready", 32'(mu_ready), 32'd0);
    for (int i = 0; i < 5; i++)
      applyStimulus(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd13);

    // WAW kill of a buffered entry.
    applyStimulus(5'd0, 32'd0, 1'b1, 5'd12, 32'h1, 5'd12, 5'd0);
    applyStimulus(5'd12, 32'h2, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
    applyStimulus(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
    applyStimulus(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);

    // Same-cycle push and writeback to one register: the entry survives.
    applyStimulus(5'd7, 32'h77, 1'b1, 5'd7, 32'h7007, 5'd7, 5'd0);
    applyStimulus(5'd2, 32'h22, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    applyStimulus(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    applyStimulus(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);

    // Starvation: one entry blocked by continuous writeback, then a bubble.
    applyStimulus(5'd3, 32'h33, 1'b1, 5'd20, 32'h2020, 5'd20, 5'd0);
    for (int i = 0; i < 12; i++)
      applyStimulus(5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 5'd20, 5'd0);
    for (int i = 0; i < 3; i++)
      applyStimulus(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd20, 5'd0);

    // Asynchronous reset with three entries buffered.
    for (int i = 0; i < 3; i++)
      applyStimulus(5'd2, 32'h22, 1'b1, 5'(21 + i), 32'hE000 + 32'(i), 5'd0, 5'd0);
    applyStimulus(5'd2, 32'h22, 1'b0, 5'd0, 32'd0, 5'd21, 5'd23);
    resetMidCycle(5'd21, 5'd23);
    for (int i = 0; i < 4; i++)
      applyStimulus(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd21, 5'd22);

    // Randomized traffic over a small register range to provoke kills/hits.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] w;
      w = ($urandom % 2 == 0) ? 5'd0 : 5'($urandom_range(1, 15));
      applyStimulus(w, $urandom, ($urandom % 10) < 6, 5'($urandom_range(0, 15)),
                    $urandom, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 20; i++)
      applyStimulus(5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
